// File: rtl/mem_responder.sv
// Memory-side responder for cache line refills and writebacks: queues requests,
// serves them in order from a line-organised backing array after a fixed latency.
module mem_responder #(
  parameter int unsigned PA_WIDTH   = 32,
  parameter int unsigned N_ELEMENTS = 4,
  parameter int unsigned N_BYTES    = 4,
  parameter int unsigned MEM_LINES  = 256,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned REQ_DEPTH  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_mem_enable,
  input  logic                                  i_mem_type,
  input  logic [PA_WIDTH-1:0]                   i_mem_addr,
  input  logic [N_ELEMENTS*N_BYTES*8-1:0]       i_mem_data,
  output logic                                  o_mem_ready,
  output logic                                  o_mem_enable,
  output logic                                  o_mem_type,
  output logic [PA_WIDTH-1:0]                   o_mem_addr,
  output logic [N_ELEMENTS*N_BYTES*8-1:0]       o_mem_data,
  input  logic                                  i_mem_ack
);

  localparam int unsigned LINE_W = N_ELEMENTS * N_BYTES * 8;
  localparam int unsigned OFF_W  = $clog2(N_ELEMENTS * N_BYTES);
  localparam int unsigned IDX_W  = $clog2(MEM_LINES);
  localparam int unsigned PTR_W  = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned OCC_W  = $clog2(REQ_DEPTH + 1);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef struct packed {
    logic                wr;
    logic [PA_WIDTH-1:0] addr;
    logic [LINE_W-1:0]   data;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pop;
  logic              commit;

  req_t              fifo [REQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              ready_q;
  logic              push;

  req_t              cur_q;
  logic [IDX_W-1:0]  cur_idx;
  logic [LINE_W-1:0] mem [MEM_LINES];

  assign push        = i_mem_enable && ready_q;
  assign o_mem_ready = ready_q;
  assign cur_idx     = cur_q.addr[OFF_W +: IDX_W];

  // Next FIFO occupancy from this cycle's push/pop
  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FIFO pointers, occupancy and registered ready (not-full) flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(REQ_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(REQ_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      occ_q   <= occ_d;
      ready_q <= (occ_d != OCC_W'(REQ_DEPTH));
    end
  end

  // FIFO storage and in-flight request capture (datapath, no reset needed)
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr_q] <= '{wr: i_mem_type, addr: i_mem_addr, data: i_mem_data};
    if (pop)  cur_q <= fifo[rd_ptr_q];
  end

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: pop, count down the latency, then hold the response until acked
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (occ_q != '0) begin
          pop     = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (i_mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Backing array write; a write caught by reset on its commit edge is dropped
  always_ff @(posedge clk) begin
    if (commit && !rst && cur_q.wr) mem[cur_idx] <= cur_q.data;
  end

  // Response registers: loaded on commit, valid dropped on ack
  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_enable <= 1'b0;
      o_mem_type   <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
    end else if (commit) begin
      o_mem_enable <= 1'b1;
      o_mem_type   <= cur_q.wr;
      o_mem_addr   <= {cur_q.addr[PA_WIDTH-1:OFF_W], OFF_W'(0)};
      o_mem_data   <= cur_q.wr ? '0 : mem[cur_idx];
    end else if (state_q == RESP && i_mem_ack) begin
      o_mem_enable <= 1'b0;
    end
  end

  // Response payload holds while waiting for the ack
  a_resp_stable: assert property (@(posedge clk) disable iff (rst)
    (o_mem_enable && !i_mem_ack) |=>
      ($stable(o_mem_type) && $stable(o_mem_addr) && $stable(o_mem_data)));

  // Occupancy bounded by the FIFO depth
  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ_q <= OCC_W'(REQ_DEPTH));

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with hand-computed expected responses.
module tb_mem_responder;

  localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
  localparam logic [127:0] L2 = 128'hA5A5_A5A5_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] L3 = 128'hCAFE_F00D_0BAD_BEEF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] L4 = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_mem_enable;
  logic         i_mem_type;
  logic [31:0]  i_mem_addr;
  logic [127:0] i_mem_data;
  logic         o_mem_ready;
  logic         o_mem_enable;
  logic         o_mem_type;
  logic [31:0]  o_mem_addr;
  logic [127:0] o_mem_data;
  logic         i_mem_ack;

  int errors = 0;
  int checks = 0;

  mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .i_mem_enable (i_mem_enable),
    .i_mem_type   (i_mem_type),
    .i_mem_addr   (i_mem_addr),
    .i_mem_data   (i_mem_data),
    .o_mem_ready  (o_mem_ready),
    .o_mem_enable (o_mem_enable),
    .o_mem_type   (o_mem_type),
    .o_mem_addr   (o_mem_addr),
    .o_mem_data   (o_mem_data),
    .i_mem_ack    (i_mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the edge that accepts it
  task automatic send(input logic wr, input logic [31:0] addr, input logic [127:0] data);
    int n = 0;
    i_mem_enable = 1'b1;
    i_mem_type   = wr;
    i_mem_addr   = addr;
    i_mem_data   = data;
    while (!o_mem_ready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) chk("send_timeout", 128'(o_mem_ready), 128'd1);
    tick();
    i_mem_enable = 1'b0;
    i_mem_type   = 1'b0;
    i_mem_addr   = '0;
    i_mem_data   = '0;
  endtask

  // Wait for a response, check it, ack it for one cycle
  task automatic get_resp(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [127:0] data);
    int n = 0;
    while (!o_mem_enable && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_en"},   128'(o_mem_enable), 128'd1);
    chk({tag, "_type"}, 128'(o_mem_type),   128'(wr));
    chk({tag, "_addr"}, 128'(o_mem_addr),   128'(addr));
    chk({tag, "_data"}, o_mem_data,         data);
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    chk({tag, "_drop"}, 128'(o_mem_enable), 128'd0);
  endtask

  initial begin
    rst          = 1'b1;
    i_mem_enable = 1'b0;
    i_mem_type   = 1'b0;
    i_mem_addr   = '0;
    i_mem_data   = '0;
    i_mem_ack    = 1'b0;
    repeat (3) tick();
    chk("rst_en",    128'(o_mem_enable), 128'd0);
    chk("rst_ready", 128'(o_mem_ready),  128'd1);
    chk("rst_addr",  128'(o_mem_addr),   128'd0);
    chk("rst_data",  o_mem_data,         128'd0);
    rst = 1'b0;
    tick();

    // Write then read back the same line
    send(1'b1, 32'h0000_0120, L1);
    get_resp("t1_wr", 1'b1, 32'h0000_0120, 128'd0);
    send(1'b0, 32'h0000_0120, '0);
    get_resp("t1_rd", 1'b0, 32'h0000_0120, L1);

    // Offset bits are zeroed in the echoed address
    send(1'b0, 32'h0000_012C, '0);
    get_resp("off_rd", 1'b0, 32'h0000_0120, L1);

    // Exact latency with ack tied high
    i_mem_ack    = 1'b1;
    i_mem_enable = 1'b1;
    i_mem_type   = 1'b0;
    i_mem_addr   = 32'h0000_0120;
    tick();
    i_mem_enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("t2_low_e%0d", k), 128'(o_mem_enable), 128'd0);
    end
    tick();
    chk("t2_high_e4", 128'(o_mem_enable), 128'd1);
    chk("t2_data",    o_mem_data,         L1);
    tick();
    chk("t2_low_e5",  128'(o_mem_enable), 128'd0);
    i_mem_ack = 1'b0;
    tick();

    // Aliasing: index ignores upper address bits
    send(1'b1, 32'h0000_0010, L2);
    get_resp("t6_wr", 1'b1, 32'h0000_0010, 128'd0);
    send(1'b0, 32'h0000_1010, '0);
    get_resp("t6_rd", 1'b0, 32'h0000_1010, L2);

    // Backpressure: one response parked, FIFO fills, next request refused
    send(1'b0, 32'h0000_0120, '0);
    for (int n = 0; n < 100 && !o_mem_enable; n++) tick();
    send(1'b0, 32'h0000_0010, '0);
    send(1'b0, 32'h0000_0120, '0);
    chk("t3_full", 128'(o_mem_ready), 128'd0);
    i_mem_enable = 1'b1;
    i_mem_addr   = 32'h0000_0040;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3_refuse%0d", k), 128'(o_mem_ready), 128'd0);
    end
    i_mem_enable = 1'b0;
    i_mem_addr   = '0;
    get_resp("t3_r0", 1'b0, 32'h0000_0120, L1);
    get_resp("t3_r1", 1'b0, 32'h0000_0010, L2);
    get_resp("t3_r2", 1'b0, 32'h0000_0120, L1);
    repeat (6) tick();
    chk("t3_empty", 128'(o_mem_enable), 128'd0);
    chk("t3_ready", 128'(o_mem_ready),  128'd1);

    // Held response stays stable; a single ack consumes exactly one
    send(1'b0, 32'h0000_0010, '0);
    for (int n = 0; n < 100 && !o_mem_enable; n++) tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("t4_en%0d", k),   128'(o_mem_enable), 128'd1);
      chk($sformatf("t4_addr%0d", k), 128'(o_mem_addr),   128'h10);
      chk($sformatf("t4_data%0d", k), o_mem_data,         L2);
    end
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t4_gone%0d", k), 128'(o_mem_enable), 128'd0);
    end

    // Reset during the latency wait of a write loses that write
    send(1'b1, 32'h0000_0040, L3);
    get_resp("t5_pre", 1'b1, 32'h0000_0040, 128'd0);
    send(1'b1, 32'h0000_0040, L4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_en",    128'(o_mem_enable), 128'd0);
    chk("t5_type",  128'(o_mem_type),   128'd0);
    chk("t5_addr",  128'(o_mem_addr),   128'd0);
    chk("t5_data",  o_mem_data,         128'd0);
    chk("t5_ready", 128'(o_mem_ready),  128'd1);
    repeat (6) tick();
    chk("t5_quiet", 128'(o_mem_enable), 128'd0);
    send(1'b0, 32'h0000_0040, '0);
    get_resp("t5_rd", 1'b0, 32'h0000_0040, L3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
